// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, branch conditions,
// control-bundle bit positions, flag positions and the ID-stage state machine.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_RED    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  localparam int SIG_W        = 7;
  localparam int SIG_JUMP     = 6;
  localparam int SIG_BRANCH   = 5;
  localparam int SIG_MEMREAD  = 4;
  localparam int SIG_MEMTOREG = 3;
  localparam int SIG_MEMWRITE = 2;
  localparam int SIG_ALUSRC   = 1;
  localparam int SIG_REGWRITE = 0;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } pipe_state_t;

  function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] flg);
    logic w_z;
    logic w_v;
    logic w_n;
    w_z = flg[FLAG_Z];
    w_v = flg[FLAG_V];
    w_n = flg[FLAG_N];
    case (ccc)
      CC_NE:   cond_met = ~w_z;
      CC_EQ:   cond_met = w_z;
      CC_GT:   cond_met = ~w_z & ~w_n;
      CC_LT:   cond_met = w_n;
      CC_GE:   cond_met = w_z | ~w_n;
      CC_LE:   cond_met = w_z | w_n;
      CC_OV:   cond_met = w_v;
      default: cond_met = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pipe_control_unit_decode.sv
// Purely combinational instruction decoder: splits fields and produces the
// control bundle, ALU op, sign-extended immediate and register-source usage.
module instr_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 16,
  localparam int INSTR_W   = 4 + 3 * REG_ADDR_W
) (
  input  logic [INSTR_W-1:0]    i_instr,
  output logic [3:0]            o_opcode,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [REG_ADDR_W-1:0] o_rs,
  output logic [REG_ADDR_W-1:0] o_rt,
  output logic [SIG_W-1:0]      o_signals,
  output logic [2:0]            o_alu_op,
  output logic [DATA_W-1:0]     o_imm,
  output logic                  o_use_rs,
  output logic                  o_use_rt,
  output logic                  o_use_rd
);

  assign o_opcode = i_instr[INSTR_W-1 -: 4];
  assign o_rd     = i_instr[INSTR_W-5 -: REG_ADDR_W];
  assign o_rs     = i_instr[INSTR_W-5-REG_ADDR_W -: REG_ADDR_W];
  assign o_rt     = i_instr[REG_ADDR_W-1:0];

  // Opcode to control bundle, immediate width and register-source usage
  always_comb begin
    o_signals = {SIG_W{1'b0}};
    o_alu_op  = o_opcode[2:0];
    o_imm     = {{(DATA_W-4){i_instr[3]}}, i_instr[3:0]};
    o_use_rs  = 1'b0;
    o_use_rt  = 1'b0;
    o_use_rd  = 1'b0;
    case (o_opcode)
      OP_ADD, OP_SUB, OP_RED, OP_XOR, OP_PADDSB: begin
        o_signals[SIG_REGWRITE] = 1'b1;
        o_use_rs = 1'b1;
        o_use_rt = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        o_signals[SIG_ALUSRC]   = 1'b1;
        o_signals[SIG_REGWRITE] = 1'b1;
        o_use_rs = 1'b1;
      end
      OP_LW: begin
        o_signals[SIG_MEMREAD]  = 1'b1;
        o_signals[SIG_MEMTOREG] = 1'b1;
        o_signals[SIG_ALUSRC]   = 1'b1;
        o_signals[SIG_REGWRITE] = 1'b1;
        o_alu_op = 3'b000;
        o_use_rs = 1'b1;
      end
      OP_SW: begin
        o_signals[SIG_MEMWRITE] = 1'b1;
        o_signals[SIG_ALUSRC]   = 1'b1;
        o_alu_op = 3'b000;
        o_use_rs = 1'b1;
        o_use_rd = 1'b1;
      end
      OP_LHB, OP_LLB: begin
        o_signals[SIG_ALUSRC]   = 1'b1;
        o_signals[SIG_REGWRITE] = 1'b1;
        o_imm    = {{(DATA_W-8){i_instr[7]}}, i_instr[7:0]};
        o_use_rd = 1'b1;
      end
      OP_B: begin
        o_signals[SIG_JUMP]   = 1'b1;
        o_signals[SIG_BRANCH] = 1'b1;
        o_imm = {{(DATA_W-9){i_instr[8]}}, i_instr[8:0]};
      end
      OP_BR: begin
        o_signals[SIG_JUMP]   = 1'b1;
        o_signals[SIG_BRANCH] = 1'b1;
        o_use_rs = 1'b1;
      end
      OP_PCS: begin
        o_signals[SIG_REGWRITE] = 1'b1;
      end
      OP_HLT: begin
        o_signals = {SIG_W{1'b0}};
      end
      default: begin
        o_signals = {SIG_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// ID-stage control: decodes into the ID/EX register and owns the flags,
// branch resolution, load-use stall, taken-branch flush and HLT drain/halt.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 4,
  parameter int DATA_W       = 16,
  parameter int DRAIN_CYCLES = 2,
  localparam int INSTR_W     = 4 + 3 * REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [INSTR_W-1:0]    if_instr,
  input  logic                  ex_flags_we,
  input  logic [2:0]            ex_flags_in,
  output logic                  id_ready,
  output logic                  ex_valid,
  output logic [SIG_W-1:0]      ex_signals,
  output logic [2:0]            ex_alu_op,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  branch_taken,
  output logic                  branch_is_reg,
  output logic [2:0]            flags,
  output logic                  halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  logic [3:0]            w_op;
  logic [REG_ADDR_W-1:0] w_rd, w_rs, w_rt;
  logic [SIG_W-1:0]      w_sig;
  logic [2:0]            w_alu_op;
  logic [DATA_W-1:0]     w_imm;
  logic                  w_use_rs, w_use_rt, w_use_rd;
  logic [2:0]            w_flags_eff;
  logic                  w_hazard, w_issue, w_take, w_halt, w_id_ready;

  pipe_state_t           r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [2:0]            r_flags;
  logic                  r_ex_valid, r_br_taken, r_br_is_reg;
  logic [SIG_W-1:0]      r_ex_sig;
  logic [2:0]            r_ex_alu_op;
  logic [DATA_W-1:0]     r_ex_imm;
  logic [REG_ADDR_W-1:0] r_ex_rd, r_ex_rs, r_ex_rt;

  instr_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_decode (
    .i_instr   (if_instr),
    .o_opcode  (w_op),
    .o_rd      (w_rd),
    .o_rs      (w_rs),
    .o_rt      (w_rt),
    .o_signals (w_sig),
    .o_alu_op  (w_alu_op),
    .o_imm     (w_imm),
    .o_use_rs  (w_use_rs),
    .o_use_rt  (w_use_rt),
    .o_use_rd  (w_use_rd)
  );

  // Flags written by EX this cycle are forwarded straight into branch evaluation
  assign w_flags_eff = ex_flags_we ? ex_flags_in : r_flags;
  assign w_hazard = if_valid & r_ex_valid & r_ex_sig[SIG_MEMREAD] &
                    ((w_use_rs & (r_ex_rd == w_rs)) |
                     (w_use_rt & (r_ex_rd == w_rt)) |
                     (w_use_rd & (r_ex_rd == w_rd)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_take)      w_next = ST_FLUSH;
        else if (w_halt) w_next = ST_DRAIN;
        else             w_next = ST_RUN;
      end
      ST_FLUSH:  w_next = ST_RUN;
      ST_DRAIN: begin
        if (r_cnt <= CNT_W'(1)) w_next = ST_HALTED;
        else                    w_next = ST_DRAIN;
      end
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_RUN;
    endcase
  end

  // Issue, branch and ready decisions
  always_comb begin
    w_issue    = 1'b0;
    w_take     = 1'b0;
    w_halt     = 1'b0;
    w_id_ready = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_issue    = if_valid & ~w_hazard;
        w_take     = w_issue & w_sig[SIG_BRANCH] &
                     cond_met(w_rd[REG_ADDR_W-1 -: 3], w_flags_eff);
        w_halt     = w_issue & (w_op == OP_HLT);
        w_id_ready = ~w_hazard & ~w_halt;
      end
      ST_FLUSH: w_id_ready = 1'b1;
      default:  w_id_ready = 1'b0;
    endcase
  end

  // Drain counter and flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_flags <= 3'b000;
    end else begin
      if (w_halt)                   r_cnt <= CNT_W'(DRAIN_CYCLES);
      else if (r_state == ST_DRAIN) r_cnt <= r_cnt - CNT_W'(1);
      else                          r_cnt <= r_cnt;
      if (ex_flags_we) r_flags <= ex_flags_in;
      else             r_flags <= r_flags;
    end
  end

  // ID/EX register; anything not issued becomes an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst || !w_issue) begin
      r_ex_valid  <= 1'b0;
      r_ex_sig    <= {SIG_W{1'b0}};
      r_ex_alu_op <= 3'b000;
      r_ex_imm    <= {DATA_W{1'b0}};
      r_ex_rd     <= {REG_ADDR_W{1'b0}};
      r_ex_rs     <= {REG_ADDR_W{1'b0}};
      r_ex_rt     <= {REG_ADDR_W{1'b0}};
    end else begin
      r_ex_valid  <= 1'b1;
      r_ex_sig    <= w_sig;
      r_ex_alu_op <= w_alu_op;
      r_ex_imm    <= w_imm;
      r_ex_rd     <= w_rd;
      r_ex_rs     <= w_rs;
      r_ex_rt     <= w_rt;
    end
  end

  // Branch redirect pulse, aligned with the branch sitting in ID/EX
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_taken  <= 1'b0;
      r_br_is_reg <= 1'b0;
    end else begin
      r_br_taken  <= w_take;
      r_br_is_reg <= w_take & (w_op == OP_BR);
    end
  end

  assign id_ready      = w_id_ready;
  assign ex_valid      = r_ex_valid;
  assign ex_signals    = r_ex_sig;
  assign ex_alu_op     = r_ex_alu_op;
  assign ex_imm        = r_ex_imm;
  assign ex_rd         = r_ex_rd;
  assign ex_rs         = r_ex_rs;
  assign ex_rt         = r_ex_rt;
  assign branch_taken  = r_br_taken;
  assign branch_is_reg = r_br_is_reg;
  assign flags         = r_flags;
  assign halted        = (r_state == ST_HALTED);

endmodule
